// File: rtl/sr_latch_driver.sv
// Drives an active-low SR latch with timed pulses and checks Q/Qbar feedback.
// Define SR_FORBID_EN to drive cmd=11 (both low) instead of rejecting it.
module sr_latch_driver #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [7:0] pulse_len,
    output logic       cmd_ready,
    output logic       S_n,
    output logic       R_n,
    input  logic       q,
    input  logic       qbar,
    output logic       done,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK
    } state_t;

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [1:0]    cmd_q, cmd_d;
    logic          qlat_q, qlat_d;
    logic          sn_q, sn_d;
    logic          rn_q, rn_d;
    logic          mism;
`ifdef SR_FORBID_EN
    logic          fbad_q, fbad_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            scnt_q  <= '0;
            cmd_q   <= 2'b00;
            qlat_q  <= 1'b0;
            sn_q    <= 1'b1;
            rn_q    <= 1'b1;
`ifdef SR_FORBID_EN
            fbad_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            cmd_q   <= cmd_d;
            qlat_q  <= qlat_d;
            sn_q    <= sn_d;
            rn_q    <= rn_d;
`ifdef SR_FORBID_EN
            fbad_q  <= fbad_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        cmd_d   = cmd_q;
        qlat_d  = qlat_q;
`ifdef SR_FORBID_EN
        fbad_d  = fbad_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_d   = cmd;
                    qlat_d  = q;
                    cnt_d   = (pulse_len == 8'd0) ? 8'd1 : pulse_len;
                    state_d = DRIVE;
`ifndef SR_FORBID_EN
                    if (cmd == 2'b11) state_d = CHECK;
`endif
                end
            end
            DRIVE: begin
                if (cnt_q <= 8'd1) begin
                    scnt_d  = SW'(SETTLE_CYC);
                    state_d = (SETTLE_CYC == 0) ? CHECK : SETTLE;
`ifdef SR_FORBID_EN
                    // forbidden drive is judged while both inputs are still low
                    fbad_d  = ~(q & qbar);
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SETTLE: begin
                if (scnt_q <= SW'(1)) state_d = CHECK;
                else scnt_d = scnt_q - SW'(1);
            end
            CHECK: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        sn_d = 1'b1;
        rn_d = 1'b1;
        if (state_d == DRIVE) begin
            sn_d = ~cmd_d[0];
            rn_d = ~cmd_d[1];
        end
    end

    always_comb begin
        mism = 1'b0;
        unique case (cmd_q)
            2'b00: mism = (q != qlat_q) || (qbar != ~qlat_q);
            2'b01: mism = ~(q & ~qbar);
            2'b10: mism = ~(~q & qbar);
            2'b11: begin
`ifdef SR_FORBID_EN
                mism = fbad_q;
`else
                mism = 1'b1;
`endif
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign S_n       = sn_q;
    assign R_n       = rn_q;
    assign done      = (state_q == CHECK);
    assign err       = done & mism;

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2: idle cycles (S_n=R_n=1) after a drive pulse and before the check.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 SHALL have port cmd_valid, input, 1: command request.
REQ-005 SHALL have port cmd, input, 2: 00 hold, 01 set, 10 reset, 11 forbidden (both inputs low).
REQ-006 SHALL have port pulse_len, input, 8: number of drive cycles; 0 is treated as 1.
REQ-007 SHALL have port cmd_ready, output, 1: high only in IDLE.
REQ-008 SHALL have port S_n, output, 1: active-low set input to the latch.
REQ-009 SHALL have port R_n, output, 1: active-low reset input to the latch.
REQ-010 SHALL have port q, input, 1: latch Q feedback.
REQ-011 SHALL have port qbar, input, 1: latch Qbar feedback.
REQ-012 SHALL have port done, output, 1: one-cycle pulse when the check completes.
REQ-013 SHALL have port err, output, 1: valid when done=1; 1 means the feedback mismatched, or the command was rejected.
REQ-014 SHALL have port busy, output, 1: equals the inverse of cmd_ready.

Function
REQ-015 SHALL implement the FSM IDLE -> DRIVE -> SETTLE -> CHECK -> IDLE.
REQ-016 SHALL accept a command on a cycle where cmd_valid=1 and cmd_ready=1, latching cmd, pulse_len and the current q.
REQ-017 SHALL ignore cmd_valid, cmd and pulse_len outside IDLE.
REQ-018 SHALL enter DRIVE on the cycle after acceptance.
REQ-019 SHALL in DRIVE drive registered S_n/R_n as: 1/1 for hold, 0/1 for set, 1/0 for reset, 0/0 for forbidden.
REQ-020 SHALL hold DRIVE for exactly max(pulse_len,1) cycles using an 8-bit down-counter with no wrap.
REQ-021 SHALL force S_n=R_n=1 in every state other than DRIVE.
REQ-022 SHALL in SETTLE wait SETTLE_CYC cycles; SETTLE_CYC=0 SHALL go directly to CHECK.
REQ-023 SHALL sample q/qbar at the start of CHECK, with these expectations: set -> q=1, qbar=0; reset -> q=0, qbar=1; hold -> q equals the latched q and qbar=~q.
REQ-024 SHALL for forbidden sample q/qbar in the last DRIVE cycle, expecting q=1, qbar=1; the CHECK-cycle values are not compared.
REQ-025 SHALL assert done for exactly one cycle, in CHECK, and drive err as the comparison result in the same cycle.
REQ-026 SHALL hold err low whenever done=0.
REQ-027 SHALL return to IDLE the cycle after CHECK, so minimum accept-to-accept spacing is 1+pulse+SETTLE_CYC+1 cycles.
REQ-028 SHALL allow back-to-back commands: cmd_valid held high is accepted again on the first IDLE cycle.

Reset
REQ-029 SHALL on rst=1 at a clk edge go to IDLE and set S_n=1, R_n=1, done=0, err=0, cmd_ready=1, busy=0, and clear the counters.
REQ-030 SHALL treat reset during DRIVE or SETTLE as an abort: no done pulse is produced, and S_n/R_n return to 1 on the next edge.
REQ-031 SHALL give rst priority over a simultaneous cmd_valid.

Configuration
REQ-032 SHALL use macro SR_FORBID_EN: when defined, cmd=11 is driven as in REQ-019 and REQ-024.
REQ-033 SHALL when SR_FORBID_EN is undefined reject cmd=11 on acceptance: no DRIVE and S_n/R_n stay 1; done=1, err=1 on the following cycle; then IDLE.

Verification
REQ-034 SHALL cover: reset, then set with pulse_len=3 and a correct NAND latch model -> S_n low for exactly 3 cycles, done with err=0 at cycle 1+3+2.
REQ-035 SHALL cover: reset with pulse_len=0 -> R_n low for 1 cycle; q=0, qbar=1 at check; err=0.
REQ-036 SHALL cover: hold after set -> S_n=R_n=1 throughout; q stays 1; err=0; with a latch model stuck at q=0, err=1.
REQ-037 SHALL cover: forbidden with pulse_len=2 -> with SR_FORBID_EN, S_n=R_n=0 for 2 cycles and err=0 when q=qbar=1; without the macro, no drive and done with err=1 one cycle after accept.
REQ-038 SHALL cover: rst asserted in the 2nd DRIVE cycle of a set pulse_len=5 -> S_n=1 on the next edge, no done, cmd_ready=1.
REQ-039 SHALL cover: cmd_valid held high with set, reset, set queued -> three done pulses, each spaced 1+pulse+SETTLE_CYC+1 cycles apart, with no overlap of S_n and R_n lows.
